// File: rtl/pcxt_chipset.sv
// PC/XT bus glue: 8088 status decode into bus commands and ALE, address latch,
// peripheral chip selects, DMA page registers and CPU read-data multiplexing.
//
// state | meaning
// IDLE  | bus passive, waiting for a non-passive status
// T1    | address latched, ALE high for this clock
// CMD   | command asserted until status returns to passive
module pcxt_chipset (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_data_bus,
  input  logic [2:0]  processor_status,
  input  logic        address_enable_n,
  input  logic        io_channel_ready,
  input  logic [7:0]  dma_read_data,
  input  logic [7:0]  pic_read_data,
  input  logic [7:0]  timer_read_data,
  input  logic [7:0]  ppi_read_data,
  input  logic [7:0]  video_read_data,
  input  logic [7:0]  ram_read_data,
  output logic [19:0] address,
  output logic        address_latch_enable,
  output logic        io_read_n,
  output logic        io_write_n,
  output logic        memory_read_n,
  output logic        memory_write_n,
  output logic        interrupt_acknowledge_n,
  output logic [7:0]  data_bus,
  output logic        data_bus_direction,
  output logic [7:0]  cpu_read_data,
  output logic        processor_ready,
  output logic        dma_chip_select_n,
  output logic        interrupt_chip_select_n,
  output logic        timer_chip_select_n,
  output logic        ppi_chip_select_n,
  output logic        video_chip_select_n,
  output logic        ram_chip_select_n,
  output logic [3:0]  dma_page_1,
  output logic [3:0]  dma_page_2,
  output logic [3:0]  dma_page_3
);

  typedef enum logic [1:0] {IDLE, T1, CMD} bus_state_t;

  bus_state_t state;
  logic [2:0] cycle_status;

  logic io_cycle, mem_cycle, write_cycle;
  logic dma_sel, pic_sel, pit_sel, ppi_sel, page_sel, video_sel, ram_sel;
  logic [4:0] io_block;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      cycle_status            <= 3'b111;
      address                 <= '0;
      address_latch_enable    <= 1'b0;
      io_read_n               <= 1'b1;
      io_write_n              <= 1'b1;
      memory_read_n           <= 1'b1;
      memory_write_n          <= 1'b1;
      interrupt_acknowledge_n <= 1'b1;
      processor_ready         <= 1'b0;
    end else if (!address_enable_n) begin
      // DMA owns the bus: abandon any CPU cycle in progress
      state                   <= IDLE;
      address_latch_enable    <= 1'b0;
      io_read_n               <= 1'b1;
      io_write_n              <= 1'b1;
      memory_read_n           <= 1'b1;
      memory_write_n          <= 1'b1;
      interrupt_acknowledge_n <= 1'b1;
      processor_ready         <= 1'b0;
    end else begin
      processor_ready <= io_channel_ready;
      case (state)
        IDLE: begin
          if (processor_status != 3'b111) begin
            state                <= T1;
            address              <= cpu_address;
            cycle_status         <= processor_status;
            address_latch_enable <= 1'b1;
          end
        end
        T1: begin
          state                   <= CMD;
          address_latch_enable    <= 1'b0;
          interrupt_acknowledge_n <= (cycle_status != 3'b000);
          io_read_n               <= (cycle_status != 3'b001);
          io_write_n              <= (cycle_status != 3'b010);
          memory_read_n           <= !((cycle_status == 3'b100) || (cycle_status == 3'b101));
          memory_write_n          <= (cycle_status != 3'b110);
        end
        CMD: begin
          if (processor_status == 3'b111) begin
            state                   <= IDLE;
            io_read_n               <= 1'b1;
            io_write_n              <= 1'b1;
            memory_read_n           <= 1'b1;
            memory_write_n          <= 1'b1;
            interrupt_acknowledge_n <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dma_page_1 <= 4'h0;
      dma_page_2 <= 4'h0;
      dma_page_3 <= 4'h0;
    end else if (!io_write_n && page_sel) begin
      case (address[1:0])
        2'b11:   dma_page_1 <= cpu_data_bus[3:0];
        2'b01:   dma_page_2 <= cpu_data_bus[3:0];
        2'b10:   dma_page_3 <= cpu_data_bus[3:0];
        default: ;
      endcase
    end
  end

  assign io_block    = address[9:5];
  assign io_cycle    = (state == CMD) && ((cycle_status == 3'b001) || (cycle_status == 3'b010));
  assign mem_cycle   = (state == CMD) && ((cycle_status == 3'b100) || (cycle_status == 3'b101) ||
                                          (cycle_status == 3'b110));
  assign write_cycle = (state == CMD) && ((cycle_status == 3'b010) || (cycle_status == 3'b110));

  assign dma_sel   = io_cycle && (io_block == 5'd0);
  assign pic_sel   = io_cycle && (io_block == 5'd1);
  assign pit_sel   = io_cycle && (io_block == 5'd2);
  assign ppi_sel   = io_cycle && (io_block == 5'd3);
  assign page_sel  = io_cycle && (io_block == 5'd4);
  assign video_sel = mem_cycle && (address[19:14] == 6'b101110);
  assign ram_sel   = mem_cycle && !video_sel && (address < 20'hA0000);

  assign dma_chip_select_n       = !dma_sel;
  assign interrupt_chip_select_n = !pic_sel;
  assign timer_chip_select_n     = !pit_sel;
  assign ppi_chip_select_n       = !ppi_sel;
  assign video_chip_select_n     = !video_sel;
  assign ram_chip_select_n       = !ram_sel;

  assign data_bus_direction = write_cycle;
  assign data_bus           = write_cycle ? cpu_data_bus : 8'hFF;

  // Page registers are write-only, so a page read falls through to FF
  always_comb begin
    cpu_read_data = 8'hFF;
    if (state == CMD) begin
      case (cycle_status)
        3'b000: cpu_read_data = pic_read_data;
        3'b001: begin
          if (dma_sel)      cpu_read_data = dma_read_data;
          else if (pic_sel) cpu_read_data = pic_read_data;
          else if (pit_sel) cpu_read_data = timer_read_data;
          else if (ppi_sel) cpu_read_data = ppi_read_data;
        end
        3'b100, 3'b101: begin
          if (video_sel)    cpu_read_data = video_read_data;
          else if (ram_sel) cpu_read_data = ram_read_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcxt_chipset.sv
// Bench for pcxt_chipset: directed bus cycles plus randomized transactions checked
// against a transaction-level model of command timing, decode and page registers.
module tb_pcxt_chipset;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_data_bus;
  logic [2:0]  processor_status;
  logic        address_enable_n;
  logic        io_channel_ready;
  logic [7:0]  dma_read_data, pic_read_data, timer_read_data;
  logic [7:0]  ppi_read_data, video_read_data, ram_read_data;
  logic [19:0] address;
  logic        address_latch_enable;
  logic        io_read_n, io_write_n, memory_read_n, memory_write_n, interrupt_acknowledge_n;
  logic [7:0]  data_bus;
  logic        data_bus_direction;
  logic [7:0]  cpu_read_data;
  logic        processor_ready;
  logic        dma_chip_select_n, interrupt_chip_select_n, timer_chip_select_n;
  logic        ppi_chip_select_n, video_chip_select_n, ram_chip_select_n;
  logic [3:0]  dma_page_1, dma_page_2, dma_page_3;

  int checks = 0;
  int errors = 0;
  logic [3:0] pg1 = 4'h0, pg2 = 4'h0, pg3 = 4'h0;
  logic exp_ready = 1'b0;

  pcxt_chipset dut (
    .clock(clock), .reset_n(reset_n), .cpu_address(cpu_address), .cpu_data_bus(cpu_data_bus),
    .processor_status(processor_status), .address_enable_n(address_enable_n),
    .io_channel_ready(io_channel_ready), .dma_read_data(dma_read_data),
    .pic_read_data(pic_read_data), .timer_read_data(timer_read_data),
    .ppi_read_data(ppi_read_data), .video_read_data(video_read_data),
    .ram_read_data(ram_read_data), .address(address),
    .address_latch_enable(address_latch_enable), .io_read_n(io_read_n),
    .io_write_n(io_write_n), .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .interrupt_acknowledge_n(interrupt_acknowledge_n), .data_bus(data_bus),
    .data_bus_direction(data_bus_direction), .cpu_read_data(cpu_read_data),
    .processor_ready(processor_ready), .dma_chip_select_n(dma_chip_select_n),
    .interrupt_chip_select_n(interrupt_chip_select_n), .timer_chip_select_n(timer_chip_select_n),
    .ppi_chip_select_n(ppi_chip_select_n), .video_chip_select_n(video_chip_select_n),
    .ram_chip_select_n(ram_chip_select_n), .dma_page_1(dma_page_1), .dma_page_2(dma_page_2),
    .dma_page_3(dma_page_3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Model: 0-3 I/O blocks DMA/PIC/PIT/PPI, 4 page registers, from address bits 9..5
  function automatic int io_block(input logic [19:0] a);
    return (int'(a) % 1024) / 32;
  endfunction

  function automatic int mem_region(input logic [19:0] a);
    if (int'(a) >= 'hB8000 && int'(a) <= 'hBBFFF) return 1;
    if (int'(a) < 'hA0000) return 2;
    return 0;
  endfunction

  function automatic logic [4:0] exp_cmd(input logic [2:0] s);
    logic [4:0] v;
    v = 5'b11111;
    case (s)
      3'd0: v[4] = 1'b0;
      3'd1: v[3] = 1'b0;
      3'd2: v[2] = 1'b0;
      3'd4, 3'd5: v[1] = 1'b0;
      3'd6: v[0] = 1'b0;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [5:0] exp_sel(input logic [2:0] s, input logic [19:0] a);
    logic [5:0] v;
    v = 6'b111111;
    if (s == 3'd1 || s == 3'd2) begin
      case (io_block(a))
        0: v[5] = 1'b0;
        1: v[4] = 1'b0;
        2: v[3] = 1'b0;
        3: v[2] = 1'b0;
        default: ;
      endcase
    end else if (s == 3'd4 || s == 3'd5 || s == 3'd6) begin
      if (mem_region(a) == 1) v[1] = 1'b0;
      else if (mem_region(a) == 2) v[0] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [2:0] s, input logic [19:0] a);
    if (s == 3'd0) return pic_read_data;
    if (s == 3'd1) begin
      case (io_block(a))
        0: return dma_read_data;
        1: return pic_read_data;
        2: return timer_read_data;
        3: return ppi_read_data;
        default: return 8'hFF;
      endcase
    end
    if (s == 3'd4 || s == 3'd5) begin
      if (mem_region(a) == 1) return video_read_data;
      if (mem_region(a) == 2) return ram_read_data;
    end
    return 8'hFF;
  endfunction

  task automatic tick();
    logic r, e;
    dma_read_data    = 8'($urandom);
    pic_read_data    = 8'($urandom);
    timer_read_data  = 8'($urandom);
    ppi_read_data    = 8'($urandom);
    video_read_data  = 8'($urandom);
    ram_read_data    = 8'($urandom);
    io_channel_ready = 1'($urandom_range(0, 1));
    r = io_channel_ready;
    e = address_enable_n;
    @(posedge clock);
    #1;
    exp_ready = r & e;
  endtask

  task automatic check_bus(input string tag, input logic ale_e, input logic active,
                           input logic [2:0] s, input logic [19:0] a, input logic [7:0] d);
    logic wr;
    wr = active && (s == 3'd2 || s == 3'd6);
    chk({tag, ".ale"}, 32'(address_latch_enable), 32'(ale_e));
    chk({tag, ".cmd"}, 32'({interrupt_acknowledge_n, io_read_n, io_write_n, memory_read_n,
                            memory_write_n}), 32'(active ? exp_cmd(s) : 5'h1F));
    chk({tag, ".sel"}, 32'({dma_chip_select_n, interrupt_chip_select_n, timer_chip_select_n,
                            ppi_chip_select_n, video_chip_select_n, ram_chip_select_n}),
        32'(active ? exp_sel(s, a) : 6'h3F));
    chk({tag, ".rd"}, 32'(cpu_read_data), 32'(active ? exp_rd(s, a) : 8'hFF));
    chk({tag, ".wdata"}, 32'({data_bus_direction, data_bus}), 32'(wr ? {1'b1, d} : 9'h0FF));
    chk({tag, ".ready"}, 32'(processor_ready), 32'(exp_ready));
    chk({tag, ".pages"}, 32'({dma_page_1, dma_page_2, dma_page_3}), 32'({pg1, pg2, pg3}));
  endtask

  task automatic model_page_write(input logic [2:0] s, input logic [19:0] a, input logic [7:0] d);
    if (s == 3'd2 && io_block(a) == 4) begin
      case (int'(a) % 4)
        3: pg1 = d[3:0];
        1: pg2 = d[3:0];
        2: pg3 = d[3:0];
        default: ;
      endcase
    end
  endtask

  // One CPU bus cycle: status s held n clocks (n >= 2), then passive for m clocks
  task automatic run_cycle(input string tag, input logic [2:0] s, input logic [19:0] a,
                           input logic [7:0] d, input int n, input int m);
    processor_status = s;
    cpu_address      = a;
    cpu_data_bus     = d;
    for (int k = 0; k < n; k++) begin
      tick();
      if (k == 1) cpu_address = 20'($urandom);
      check_bus(tag, k == 0, k >= 1, s, a, d);
      chk({tag, ".addr"}, 32'(address), 32'(a));
      if (k == 1) model_page_write(s, a, d);
    end
    processor_status = 3'b111;
    for (int j = 0; j < m; j++) begin
      tick();
      check_bus({tag, ".idle"}, 1'b0, 1'b0, s, a, d);
    end
  endtask

  initial begin
    logic [2:0]  rs;
    logic [19:0] ra;
    reset_n          = 1'b0;
    cpu_address      = 20'h0;
    cpu_data_bus     = 8'h00;
    processor_status = 3'b111;
    address_enable_n = 1'b1;
    io_channel_ready = 1'b1;
    dma_read_data = 8'h11; pic_read_data = 8'h22; timer_read_data = 8'h33;
    ppi_read_data = 8'h44; video_read_data = 8'h55; ram_read_data = 8'h66;

    repeat (2) @(posedge clock);
    #1;
    chk("reset.addr", 32'(address), 32'h0);
    check_bus("reset", 1'b0, 1'b0, 3'd7, 20'h0, 8'h0);
    reset_n = 1'b1;
    tick();
    check_bus("post_reset", 1'b0, 1'b0, 3'd7, 20'h0, 8'h0);

    run_cycle("ior_12345", 3'd1, 20'h12345, 8'h00, 4, 2);
    run_cycle("iow_ppi", 3'd2, 20'h00061, 8'h55, 3, 2);
    run_cycle("page83", 3'd2, 20'h00083, 8'h01, 3, 1);
    run_cycle("page81", 3'd2, 20'h00081, 8'h02, 2, 1);
    run_cycle("page82", 3'd2, 20'h00082, 8'h03, 4, 2);
    chk("pages_123", 32'({dma_page_1, dma_page_2, dma_page_3}), 32'h123);
    run_cycle("ior_page", 3'd1, 20'h00083, 8'h00, 3, 1);
    run_cycle("inta1", 3'd0, 20'h00000, 8'h00, 4, 2);
    run_cycle("inta2", 3'd0, 20'h00000, 8'h00, 4, 2);
    run_cycle("memw_b8001", 3'd6, 20'hB8001, 8'h02, 3, 1);
    run_cycle("memr_b8000", 3'd5, 20'hB8000, 8'h00, 3, 1);
    run_cycle("memr_def01", 3'd5, 20'hDEF01, 8'h00, 3, 1);
    run_cycle("halt", 3'd3, 20'h00000, 8'h00, 3, 1);

    for (int i = 0; i < 60; i++) begin
      rs = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: ra = (20'($urandom) & 20'hFFC00) | 20'($urandom_range(0, 255));
        1: ra = 20'($urandom_range(0, 'h9FFFF));
        2: ra = 20'($urandom_range('hB8000, 'hBBFFF));
        default: ra = 20'($urandom_range('hA0000, 'hFFFFF));
      endcase
      run_cycle("rand", rs, ra, 8'($urandom), $urandom_range(2, 5), $urandom_range(1, 3));
    end

    // Status switching straight to another active value keeps the original cycle
    processor_status = 3'd1;
    cpu_address      = 20'h00040;
    tick();
    check_bus("chg.t1", 1'b1, 1'b0, 3'd1, 20'h00040, 8'h0);
    tick();
    check_bus("chg.cmd", 1'b0, 1'b1, 3'd1, 20'h00040, 8'h0);
    processor_status = 3'd5;
    cpu_address      = 20'h01000;
    repeat (2) begin
      tick();
      check_bus("chg.hold", 1'b0, 1'b1, 3'd1, 20'h00040, 8'h0);
    end
    processor_status = 3'b111;
    tick();
    check_bus("chg.idle", 1'b0, 1'b0, 3'd1, 20'h00040, 8'h0);

    // DMA holds the bus during a memory-read request
    address_enable_n = 1'b0;
    processor_status = 3'd5;
    cpu_address      = 20'h01234;
    repeat (3) begin
      tick();
      check_bus("aen.held", 1'b0, 1'b0, 3'd5, 20'h01234, 8'h0);
    end
    address_enable_n = 1'b1;
    tick();
    check_bus("aen.t1", 1'b1, 1'b0, 3'd5, 20'h01234, 8'h0);
    chk("aen.addr", 32'(address), 32'h01234);
    tick();
    check_bus("aen.cmd", 1'b0, 1'b1, 3'd5, 20'h01234, 8'h0);
    processor_status = 3'b111;
    tick();
    check_bus("aen.idle", 1'b0, 1'b0, 3'd5, 20'h01234, 8'h0);

    // Reset in the middle of a memory write
    processor_status = 3'd6;
    cpu_address      = 20'hB8010;
    cpu_data_bus     = 8'hA5;
    tick();
    tick();
    check_bus("rst.cmd", 1'b0, 1'b1, 3'd6, 20'hB8010, 8'hA5);
    reset_n = 1'b0;
    #1;
    pg1 = 4'h0; pg2 = 4'h0; pg3 = 4'h0;
    exp_ready = 1'b0;
    chk("rst.addr", 32'(address), 32'h0);
    check_bus("rst.mid", 1'b0, 1'b0, 3'd6, 20'h0, 8'h0);
    processor_status = 3'b111;
    reset_n = 1'b1;
    tick();
    check_bus("rst.after", 1'b0, 1'b0, 3'd6, 20'h0, 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
